// File: rtl/tile_pkg.sv
// Shared types and default colours for the tile rasteriser.
// Imported by tile_shader and tile_drawer.
package tile_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DRAW = 2'd1,
        ST_DONE = 2'd2
    } tile_state_t;

    typedef enum logic [1:0] {
        STYLE_EMPTY          = 2'd0,
        STYLE_FILLED         = 2'd1,
        STYLE_OUTLINE        = 2'd2,
        STYLE_OUTLINE_FILLED = 2'd3
    } tile_style_t;

    localparam logic [23:0] DEF_BG_COLOR     = 24'h000000;
    localparam logic [23:0] DEF_FILL_COLOR   = 24'hB2E1F2;
    localparam logic [23:0] DEF_BORDER_COLOR = 24'hC7B8E4;

endpackage

// File: rtl/tile_shader.sv
// Combinational pixel colour for a position inside a tile.
// Border test is done one bit wider so BORDER=0 never matches.
module tile_shader
    import tile_pkg::*;
#(
    parameter int          TILE_SIZE    = 16,
    parameter int          BORDER       = 2,
    parameter logic [23:0] BG_COLOR     = DEF_BG_COLOR,
    parameter logic [23:0] FILL_COLOR   = DEF_FILL_COLOR,
    parameter logic [23:0] BORDER_COLOR = DEF_BORDER_COLOR,
    parameter int          CW           = $clog2(TILE_SIZE)
) (
    input  tile_style_t   style_i,
    input  logic [CW-1:0] cx_i,
    input  logic [CW-1:0] cy_i,
    output logic [23:0]   rgb_o
);

    localparam logic [CW:0] LO = (CW+1)'(BORDER);
    localparam logic [CW:0] HI = (CW+1)'(TILE_SIZE - BORDER);

    logic on_border;

    assign on_border = ({1'b0, cx_i} <  LO) ||
                       ({1'b0, cy_i} <  LO) ||
                       ({1'b0, cx_i} >= HI) ||
                       ({1'b0, cy_i} >= HI);

    always_comb begin
        rgb_o = BG_COLOR;
        unique case (style_i)
            STYLE_EMPTY:          rgb_o = BG_COLOR;
            STYLE_FILLED:         rgb_o = FILL_COLOR;
            STYLE_OUTLINE:        rgb_o = on_border ? BORDER_COLOR : BG_COLOR;
            STYLE_OUTLINE_FILLED: rgb_o = on_border ? BORDER_COLOR : FILL_COLOR;
            default:              rgb_o = BG_COLOR;
        endcase
    end

endmodule

// File: rtl/tile_drawer.sv
// Streams every pixel of one TILE_SIZE x TILE_SIZE tile over valid/ready.
// Outputs are registered from next-state counters so a stall holds them.
module tile_drawer
    import tile_pkg::*;
#(
    parameter int          TILE_SIZE    = 16,
    parameter int          BORDER       = 2,
    parameter int          X_BITS       = 10,
    parameter int          Y_BITS       = 9,
    parameter logic [23:0] BG_COLOR     = DEF_BG_COLOR,
    parameter logic [23:0] FILL_COLOR   = DEF_FILL_COLOR,
    parameter logic [23:0] BORDER_COLOR = DEF_BORDER_COLOR,
    parameter int          CW           = $clog2(TILE_SIZE)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [X_BITS-CW-1:0] tile_x,
    input  logic [Y_BITS-CW-1:0] tile_y,
    input  logic [1:0]           style,
    output logic                 busy,
    output logic                 pixel_valid,
    input  logic                 pixel_ready,
    output logic [X_BITS-1:0]    x,
    output logic [Y_BITS-1:0]    y,
    output logic [7:0]           r,
    output logic [7:0]           g,
    output logic [7:0]           b,
    output logic                 done
);

    localparam logic [CW-1:0] CMAX = '1;

    tile_state_t          state_q, state_d;
    tile_style_t          style_q, style_d;
    logic [X_BITS-CW-1:0] tx_q, tx_d;
    logic [Y_BITS-CW-1:0] ty_q, ty_d;
    logic [CW-1:0]        cx_q, cx_d;
    logic [CW-1:0]        cy_q, cy_d;
    logic [X_BITS-1:0]    x_q;
    logic [Y_BITS-1:0]    y_q;
    logic [23:0]          rgb_q, rgb_d;
    logic                 valid_q, busy_q, done_q;

    tile_shader #(
        .TILE_SIZE    (TILE_SIZE),
        .BORDER       (BORDER),
        .BG_COLOR     (BG_COLOR),
        .FILL_COLOR   (FILL_COLOR),
        .BORDER_COLOR (BORDER_COLOR),
        .CW           (CW)
    ) u_shader (
        .style_i (style_d),
        .cx_i    (cx_d),
        .cy_i    (cy_d),
        .rgb_o   (rgb_d)
    );

    always_comb begin
        state_d = state_q;
        style_d = style_q;
        tx_d    = tx_q;
        ty_d    = ty_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_DRAW;
                    style_d = tile_style_t'(style);
                    tx_d    = tile_x;
                    ty_d    = tile_y;
                    cx_d    = '0;
                    cy_d    = '0;
                end
            end
            ST_DRAW: begin
                if (pixel_ready) begin
                    if (cx_q == CMAX) begin
                        cx_d = '0;
                        if (cy_q == CMAX) state_d = ST_DONE;
                        else              cy_d    = cy_q + 1'b1;
                    end else begin
                        cx_d = cx_q + 1'b1;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            style_q <= STYLE_EMPTY;
            tx_q    <= '0;
            ty_q    <= '0;
            cx_q    <= '0;
            cy_q    <= '0;
            x_q     <= '0;
            y_q     <= '0;
            rgb_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            style_q <= style_d;
            tx_q    <= tx_d;
            ty_q    <= ty_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            valid_q <= (state_d == ST_DRAW);
            busy_q  <= (state_d != ST_IDLE);
            done_q  <= (state_d == ST_DONE);
            if (state_d == ST_DRAW) begin
                x_q   <= {tx_d, cx_d};
                y_q   <= {ty_d, cy_d};
                rgb_q <= rgb_d;
            end
        end
    end

    assign busy        = busy_q;
    assign pixel_valid = valid_q;
    assign done        = done_q;
    assign x           = x_q;
    assign y           = y_q;
    assign r           = rgb_q[23:16];
    assign g           = rgb_q[15:8];
    assign b           = rgb_q[7:0];

endmodule

// File: tb/tb_tile_drawer.sv
// Randomised bench for tile_drawer against a raster-order pixel model.
// Instance A uses default parameters, instance B a 8x8 tile with 1px border.
module tb_tile_drawer;

    localparam logic [23:0] BG  = 24'h000000;
    localparam logic [23:0] FIL = 24'hB2E1F2;
    localparam logic [23:0] BRD = 24'hC7B8E4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic rdy = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic sel = 1'b0;

    logic       start_a = 1'b0;
    logic [5:0] tx_a = '0;
    logic [4:0] ty_a = '0;
    logic [1:0] st_a = '0;
    logic       busy_a, val_a, done_a;
    logic [9:0] x_a;
    logic [8:0] y_a;
    logic [7:0] r_a, g_a, b_a;

    logic       start_b = 1'b0;
    logic [6:0] tx_b = '0;
    logic [5:0] ty_b = '0;
    logic [1:0] st_b = '0;
    logic       busy_b, val_b, done_b;
    logic [9:0] x_b;
    logic [8:0] y_b;
    logic [7:0] r_b, g_b, b_b;

    logic        o_valid, o_busy, o_done;
    logic [9:0]  o_x;
    logic [8:0]  o_y;
    logic [23:0] o_rgb;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    tile_drawer u_a (
        .clk(clk), .reset_n(reset_n), .start(start_a),
        .tile_x(tx_a), .tile_y(ty_a), .style(st_a),
        .busy(busy_a), .pixel_valid(val_a), .pixel_ready(rdy),
        .x(x_a), .y(y_a), .r(r_a), .g(g_a), .b(b_a), .done(done_a)
    );

    tile_drawer #(.TILE_SIZE(8), .BORDER(1)) u_b (
        .clk(clk), .reset_n(reset_n), .start(start_b),
        .tile_x(tx_b), .tile_y(ty_b), .style(st_b),
        .busy(busy_b), .pixel_valid(val_b), .pixel_ready(rdy),
        .x(x_b), .y(y_b), .r(r_b), .g(g_b), .b(b_b), .done(done_b)
    );

    always_comb begin
        o_valid = sel ? val_b  : val_a;
        o_busy  = sel ? busy_b : busy_a;
        o_done  = sel ? done_b : done_a;
        o_x     = sel ? x_b    : x_a;
        o_y     = sel ? y_b    : y_a;
        o_rgb   = sel ? {r_b, g_b, b_b} : {r_a, g_a, b_a};
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] model_rgb(int ts, int bd, int st,
                                              int cx, int cy);
        bit          in_border;
        logic [23:0] inner;
        in_border = (cx < bd) || (cy < bd) ||
                    (cx >= ts - bd) || (cy >= ts - bd);
        inner = (st % 2 == 1) ? FIL : BG;
        if (st >= 2 && in_border) return BRD;
        return inner;
    endfunction

    task automatic drive_tile(input bit s, input bit go, input int tx,
                              input int ty, input int st);
        if (s) begin
            start_b = go; tx_b = 7'(tx); ty_b = 6'(ty); st_b = 2'(st);
        end else begin
            start_a = go; tx_a = 6'(tx); ty_a = 5'(ty); st_a = 2'(st);
        end
    endtask

    // mode: 0 ready high, 1 ready 0/1 alternating, 2 random ready
    task automatic run_tile(input bit s, input int ts, input int bd,
                            input int tx, input int ty, input int st,
                            input int mode, input bit mid_start,
                            input int abort_at);
        int total, idx, ncyc;
        total = ts * ts;
        sel = s;
        @(negedge clk);
        rdy = 1'b0;
        drive_tile(s, 1'b1, tx, ty, st);
        @(negedge clk);
        drive_tile(s, 1'b0, int'($urandom), int'($urandom), int'($urandom));
        check("busy_after_start", o_busy, 1);
        idx = 0;
        ncyc = 0;
        while (idx < total && ncyc < 4 * total + 16) begin
            check("valid", o_valid, 1);
            check("done_low", o_done, 0);
            check("x", o_x, tx * ts + idx % ts);
            check("y", o_y, ty * ts + idx / ts);
            check("rgb", o_rgb, model_rgb(ts, bd, st, idx % ts, idx / ts));
            if (abort_at >= 0 && idx == abort_at) begin
                reset_n = 1'b0;
                #1;
                check("rst_valid", o_valid, 0);
                check("rst_busy", o_busy, 0);
                check("rst_x", o_x, 0);
                check("rst_y", o_y, 0);
                check("rst_rgb", o_rgb, 0);
                #1;
                reset_n = 1'b1;
                @(negedge clk);
                check("rst_no_done", o_done, 0);
                check("rst_idle", o_busy, 0);
                return;
            end
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (ncyc % 2 == 1);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            if (mid_start && idx == 5) drive_tile(s, 1'b1, 1, 1, st);
            else if (s) start_b = 1'b0;
            else        start_a = 1'b0;
            @(posedge clk);
            ncyc++;
            if (rdy) idx++;
            @(negedge clk);
        end
        start_a = 1'b0;
        start_b = 1'b0;
        check("accepts", idx, total);
        if (mode == 1) check("toggle_cycles", ncyc, 2 * total);
        check("done_pulse", o_done, 1);
        check("done_valid_low", o_valid, 0);
        @(negedge clk);
        check("done_one_cycle", o_done, 0);
        check("idle_busy", o_busy, 0);
    endtask

    task automatic back_to_back();
        int  t0, t1;
        bit  found, prev;
        sel = 1'b0;
        rdy = 1'b1;
        @(negedge clk);
        drive_tile(1'b0, 1'b1, 2, 3, 0);
        @(negedge clk);
        t0 = cyc;
        check("b2b_first_valid", o_valid, 1);
        check("b2b_first_x", o_x, 32);
        check("b2b_first_rgb", o_rgb, BG);
        drive_tile(1'b0, 1'b1, 3, 2, 1);
        prev = 1'b1;
        found = 1'b0;
        t1 = 0;
        for (int k = 0; k < 600 && !found; k++) begin
            @(negedge clk);
            if (o_valid && !prev) begin
                found = 1'b1;
                t1 = cyc;
            end
            prev = o_valid;
        end
        start_a = 1'b0;
        check("b2b_found", found, 1);
        check("b2b_period", t1 - t0, 258);
        check("b2b_second_x", o_x, 48);
        check("b2b_second_y", o_y, 32);
        check("b2b_second_rgb", o_rgb, FIL);
        for (int k = 0; k < 600 && o_busy; k++) @(negedge clk);
        check("b2b_drained", o_busy, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset_valid", val_a, 0);
        check("reset_busy", busy_a, 0);
        check("reset_done", done_a, 0);
        check("reset_x", x_a, 0);
        check("reset_y", y_a, 0);
        check("reset_rgb", {r_a, g_a, b_a}, 0);
        check("reset_b_valid", val_b, 0);
        reset_n = 1'b1;

        run_tile(1'b0, 16, 2, 4, 4, 2, 0, 1'b0, -1);
        run_tile(1'b0, 16, 2, 0, 0, 1, 1, 1'b0, -1);
        run_tile(1'b0, 16, 2, 5, 6, 3, 2, 1'b1, -1);
        run_tile(1'b0, 16, 2, 7, 2, 3, 0, 1'b0, 100);
        run_tile(1'b0, 16, 2, 0, 0, 3, 2, 1'b0, -1);
        back_to_back();
        run_tile(1'b1, 8, 1, 79, 59, 3, 2, 1'b0, -1);
        for (int t = 0; t < 2; t++)
            run_tile(1'b0, 16, 2, $urandom_range(0, 39),
                     $urandom_range(0, 29), $urandom_range(0, 3),
                     2, 1'b0, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
